// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a PC-indexed table of 2-bit saturating counters,
// trained by branch resolution, with misprediction flag and saturating statistics.
module branch_predictor #(
  parameter int ADDR_SIZE  = 32,
  parameter int TABLE_BITS = 6,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lookup_valid,
  input  logic [ADDR_SIZE-1:0]  lookup_pc,
  output logic                  predict_taken,
  input  logic                  update_valid,
  input  logic [ADDR_SIZE-1:0]  update_pc,
  input  logic                  update_taken,
  input  logic                  update_predicted,
  output logic                  mispredict,
  output logic [COUNT_BITS-1:0] branch_count,
  output logic [COUNT_BITS-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << TABLE_BITS;

  logic [1:0]            pht [ENTRIES];
  logic [TABLE_BITS-1:0] lookup_index;
  logic [TABLE_BITS-1:0] update_index;
  logic                  unused_pc_bits;

  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [COUNT_BITS-1:0] sat_count(input logic [COUNT_BITS-1:0] c);
    return (&c) ? c : c + {{(COUNT_BITS-1){1'b0}}, 1'b1};
  endfunction

  // Word-aligned PCs: drop the byte offset, no tag bits kept.
  assign lookup_index = lookup_pc[TABLE_BITS+1:2];
  assign update_index = update_pc[TABLE_BITS+1:2];

  assign unused_pc_bits = ^{lookup_pc[ADDR_SIZE-1:TABLE_BITS+2], lookup_pc[1:0],
                            update_pc[ADDR_SIZE-1:TABLE_BITS+2], update_pc[1:0]};

  // Lookup reads pre-update table state; no bypass from a same-cycle update.
  assign predict_taken = lookup_valid & pht[lookup_index][1];
  assign mispredict    = update_valid & (update_taken != update_predicted);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht[i] <= 2'b01;
      end
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (update_valid) begin
      pht[update_index] <= update_taken ? sat_inc2(pht[update_index])
                                        : sat_dec2(pht[update_index]);
      branch_count <= sat_count(branch_count);
      if (mispredict) begin
        mispredict_count <= sat_count(mispredict_count);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed test-plan scenarios plus
// randomized traffic, all checked against an array-based reference model.
module tb_branch_predictor;

  localparam int ENTRIES   = 64;
  localparam int BIG_MAX   = 65535;
  localparam int SMALL_MAX = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        update_valid = 1'b0;
  logic [31:0] update_pc = '0;
  logic        update_taken = 1'b0;
  logic        update_predicted = 1'b0;

  logic        predict_taken, mispredict;
  logic [15:0] branch_count, mispredict_count;
  logic        s_predict_taken, s_mispredict;
  logic [3:0]  s_branch_count, s_mispredict_count;

  int tests = 0;
  int failed = 0;

  int  model_tbl [ENTRIES];
  int  m_branches, m_mispreds, s_branches, s_mispreds;
  bit  model_valid = 1'b0;

  always #5 clk = ~clk;

  branch_predictor #(.ADDR_SIZE(32), .TABLE_BITS(6), .COUNT_BITS(16)) dut (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .predict_taken(predict_taken),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_predicted(update_predicted), .mispredict(mispredict),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_predictor #(.ADDR_SIZE(32), .TABLE_BITS(6), .COUNT_BITS(4)) dut_small (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .predict_taken(s_predict_taken),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_predicted(update_predicted), .mispredict(s_mispredict),
    .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  // One clock cycle: drive inputs, check combinational/registered outputs mid-cycle,
  // then advance the model at the rising edge. exp_pred >= 0 adds a directed check.
  task automatic tick(input bit rst_i, input bit lv, input logic [31:0] lpc,
                      input bit uv, input logic [31:0] upc, input bit ut, input bit up,
                      input int exp_pred = -1, input string tag = "directed");
    bit m_pred, m_mis;
    reset = rst_i;
    lookup_valid = lv;
    lookup_pc = lpc;
    update_valid = uv;
    update_pc = upc;
    update_taken = uv ? ut : 1'bx;
    update_predicted = up;
    @(negedge clk);
    m_mis = uv && (ut != up);
    if (model_valid) begin
      m_pred = lv && (model_tbl[idx_of(lpc)] >= 2);
      check("predict", {31'd0, predict_taken}, {31'd0, m_pred});
      check("s_predict", {31'd0, s_predict_taken}, {31'd0, m_pred});
      check("mispredict", {31'd0, mispredict}, {31'd0, m_mis});
      check("branch_count", {16'd0, branch_count}, m_branches);
      check("mispredict_count", {16'd0, mispredict_count}, m_mispreds);
      check("s_branch_count", {28'd0, s_branch_count}, s_branches);
      check("s_mispredict_count", {28'd0, s_mispredict_count}, s_mispreds);
    end
    if (exp_pred >= 0) check(tag, {31'd0, predict_taken}, exp_pred);
    @(posedge clk);
    if (rst_i) begin
      foreach (model_tbl[i]) model_tbl[i] = 1;
      m_branches = 0; m_mispreds = 0; s_branches = 0; s_mispreds = 0;
      model_valid = 1'b1;
    end else if (model_valid && uv) begin
      if (ut) model_tbl[idx_of(upc)] = (model_tbl[idx_of(upc)] == 3) ? 3 : model_tbl[idx_of(upc)] + 1;
      else    model_tbl[idx_of(upc)] = (model_tbl[idx_of(upc)] == 0) ? 0 : model_tbl[idx_of(upc)] - 1;
      if (m_branches < BIG_MAX) m_branches++;
      if (s_branches < SMALL_MAX) s_branches++;
      if (m_mis && m_mispreds < BIG_MAX) m_mispreds++;
      if (m_mis && s_mispreds < SMALL_MAX) s_mispreds++;
    end
    #1;
  endtask

  task automatic look(input logic [31:0] pc, input int exp, input string tag);
    tick(0, 1, pc, 0, 32'h0, 0, 0, exp, tag);
  endtask

  task automatic upd(input logic [31:0] pc, input bit t, input bit p);
    tick(0, 0, 32'h0, 1, pc, t, p);
  endtask

  initial begin
    // Reset state
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    look(32'h0,   0, "reset_pc0");
    look(32'h40,  0, "reset_pc40");
    look(32'hFFC, 0, "reset_pcffc");
    check("reset_bcount", {16'd0, branch_count}, 0);
    check("reset_mcount", {16'd0, mispredict_count}, 0);

    // Single training step
    tick(0, 0, 0, 1, 32'h40, 1, 0);
    look(32'h40, 1, "single_pred");
    check("single_bcount", {16'd0, branch_count}, 1);
    check("single_mcount", {16'd0, mispredict_count}, 1);

    // Saturation at 0x80
    repeat (4) upd(32'h80, 1, 1);
    upd(32'h80, 0, 1);
    look(32'h80, 1, "sat_st_to_wt");
    repeat (2) upd(32'h80, 0, 1);
    look(32'h80, 0, "sat_down_snt");
    repeat (5) upd(32'h80, 0, 0);
    upd(32'h80, 1, 0);
    look(32'h80, 0, "sat_floor_held");

    // Aliasing
    upd(32'h40, 1, 1);
    look(32'h140, 1, "alias_140");
    look(32'h44,  0, "alias_44");

    // Same-cycle lookup/update hazard from reset state
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 32'h200, 1, 32'h200, 1, 0, 0, "hazard_same_cycle");
    look(32'h200, 1, "hazard_next_cycle");

    // Reset priority over simultaneous update
    tick(1, 0, 0, 1, 32'h300, 1, 0);
    look(32'h300, 0, "rstprio_pred");
    check("rstprio_bcount", {16'd0, branch_count}, 0);
    check("rstprio_mcount", {16'd0, mispredict_count}, 0);
    upd(32'h300, 0, 0);
    upd(32'h300, 1, 0);
    look(32'h300, 0, "rstprio_entry_was_wnt");

    // Counter saturation on the 4-bit instance
    tick(1, 0, 0, 0, 0, 0, 0);
    repeat (20) upd(32'h10, 1, 0);
    look(32'h10, 1, "cnt_sat_pred");
    check("cnt_sat_bcount", {28'd0, s_branch_count}, 15);
    check("cnt_sat_mcount", {28'd0, s_mispredict_count}, 15);
    check("cnt_big_bcount", {16'd0, branch_count}, 20);

    // Randomized traffic over a narrow PC range to exercise aliasing
    tick(1, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      tick(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1,
           {22'd0, 10'($urandom_range(0, 1023))},
           $urandom_range(0, 3) != 0, {22'd0, 10'($urandom_range(0, 1023))},
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Bimodal branch predictor for the MIPS pipeline. It keeps a table of 2-bit saturating counters indexed by PC. The fetch/decode side queries the table for a taken/not-taken prediction. The table is trained by the branch resolution stage, which produces the actual outcome from the `is_zero` comparison of `rs - rt` for beq/bne. The block also flags mispredictions so the pipeline can flush, and keeps saturating statistics counters for debug readout.

## Interface
Parameters:
- `ADDR_SIZE`, 32: PC width in bits.
- `TABLE_BITS`, 6: log2 of the number of table entries (default 64).
- `COUNT_BITS`, 16: width of each statistics counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `lookup_valid` in 1: a branch is being looked up this cycle.
- `lookup_pc` in `ADDR_SIZE`: PC of the branch being looked up.
- `predict_taken` out 1: prediction for `lookup_pc`; combinational from table state.
- `update_valid` in 1: a resolved branch is presented this cycle.
- `update_pc` in `ADDR_SIZE`: PC of the resolved branch.
- `update_taken` in 1: actual outcome from the resolution stage.
- `update_predicted` in 1: prediction that was carried down the pipe with this branch.
- `mispredict` out 1: combinational, `update_valid & (update_taken != update_predicted)`.
- `branch_count` out `COUNT_BITS`: registered count of resolved branches.
- `mispredict_count` out `COUNT_BITS`: registered count of mispredictions.

## Operation
- **Index:** `pc[TABLE_BITS+1:2]`. PC bits [1:0] are ignored. PCs that differ by a multiple of `4 << TABLE_BITS` alias to the same entry; no tags are kept.
- **Counter encoding and states:**
  - 00 = strongly not-taken (SNT)
  - 01 = weakly not-taken (WNT)
  - 10 = weakly taken (WT)
  - 11 = strongly taken (ST)
- **Update rule:** when `update_valid` is high, the indexed entry changes at the clock edge:
  - `update_taken`=1: increment, saturating at 11.
  - `update_taken`=0: decrement, saturating at 00.
  - Entries not indexed are unchanged.
- **Prediction:** `predict_taken = lookup_valid & entry[lookup_index][1]`. If `lookup_valid`=0, the output is 0.
- **Statistics:** on each cycle with `update_valid`=1:
  - `branch_count` increments.
  - `mispredict_count` increments when `mispredict`=1.
  - Both saturate at all-ones; they never wrap.
- **Misprediction:** `mispredict` only signals the event. Flushing and PC redirect are the pipeline control's job.

## Timing
- **Reset:** on a clock edge with `reset`=1:
  - All table entries are set to 01 (WNT).
  - `branch_count` = 0 and `mispredict_count` = 0.
  - `reset` has priority over a simultaneous update; that update is discarded.
  - As a result, `predict_taken` reads 0 for every PC from the first cycle after reset.
- **Update latency:** one cycle. An update at edge N is visible on `predict_taken` in the cycle after edge N.
- **Same cycle, same index:** when lookup and update hit the same index in one cycle, the lookup returns the pre-update value. There is no bypass.
- **Reset mid-operation:** training is lost. The pipeline re-presents nothing, and the block keeps no pending state.
- **Combinational outputs:** `mispredict` and `predict_taken` have no registered delay. Both counters are registered and show the new value one cycle after the qualifying update.
- **Unknown inputs:** X or Z on `update_taken` while `update_valid`=0 must not alter state.

## Test plan
- **Reset state:** assert `reset` for 2 cycles, then look up PCs 0x0, 0x40 and 0xFFC → `predict_taken`=0; both counters read 0.
- **Single training step:** one update at PC 0x40 with taken=1, predicted=0 → next cycle:
  - lookup 0x40 gives `predict_taken`=1;
  - `mispredict` was 1 during the update cycle;
  - `branch_count`=1, `mispredict_count`=1.
- **Saturation:**
  - Four taken updates at 0x80, then one not-taken → lookup still predicts 1 (11→10).
  - Two more not-taken → predicts 0.
  - Five further not-taken → entry held at 00; one taken afterwards → still predicts 0.
- **Aliasing:** train 0x40 taken once, then look up 0x140 (`TABLE_BITS`=6) → `predict_taken`=1; lookup 0x44 → 0.
- **Same-cycle hazard:** lookup and taken update both at 0x200 from reset state → lookup returns 0 in that cycle and 1 in the following cycle.
- **Reset priority and counter saturation:**
  - Update and `reset` asserted together → entry stays 01 and counters stay 0.
  - With `COUNT_BITS`=4, apply 20 mispredicted updates → both counters read 0xF.
